ila: RTL and testbench
======================

# ila

Three-probe integrated logic analyzer core for on-chip debug of datapath signals, e.g. a classifier stage's rectangle sum, accumulated sum and classifier sum. It continuously samples three 16-bit probe buses on the system clock once armed. It evaluates a masked-compare trigger and stores a pre/post-trigger window in an internal circular sample memory. A simple synchronous read port drains the memory after capture.

## Interface
- PROBE_WIDTH, 16, width of each probe bus.
- DEPTH, 256, number of sample words; must be a power of two and at least 4.
- ADDR_W, $clog2(DEPTH), address width; derived, do not override.

- clk  in  1  sole clock; all logic on rising edge.
- reset  in  1  synchronous, active-high; one clock, reset is synchronous and active-high.
- probe0  in  PROBE_WIDTH  probe bus 0.
- probe1  in  PROBE_WIDTH  probe bus 1.
- probe2  in  PROBE_WIDTH  probe bus 2.
- arm  in  1  single-cycle pulse; starts or restarts a capture.
- trig_sel  in  2  selects the compared probe: 0/1/2 = probe0/1/2; 3 = unconditional trigger.
- trig_value  in  PROBE_WIDTH  trigger compare value.
- trig_mask  in  PROBE_WIDTH  trigger compare mask; a 1 bit means the bit is compared.
- pre_trigger  in  ADDR_W  samples retained before the trigger sample (0..DEPTH-1).
- rd_en  in  1  read request.
- rd_addr  in  ADDR_W  read address.
- rd_data  out  3*PROBE_WIDTH  sample word {probe2, probe1, probe0}.
- rd_valid  out  1  rd_data valid strobe.
- state  out  2  0=IDLE, 1=ARMED, 2=TRIGGERED, 3=DONE.
- trig_addr  out  ADDR_W  memory address of the trigger sample.
- start_addr  out  ADDR_W  address of the oldest sample in the window: (trig_addr − pre_trigger) mod DEPTH.

## Operation
- Sample word = {probe2, probe1, probe0}, captured at the rising edge.
- Trigger match = ((selected probe & trig_mask) == (trig_value & trig_mask)), or always true when trig_sel = 3. trig_mask = 0 therefore also always matches.
- IDLE: no memory writes. An arm pulse moves to ARMED, clears wr_ptr and pre_count, and latches pre_trigger and the trigger configuration as P, sel, value and mask.
- ARMED: every edge writes the sample at wr_ptr; wr_ptr increments modulo DEPTH; pre_count increments, saturating at P.
  - If pre_count (before this edge) == P and match: trig_addr ← wr_ptr, post_count ← DEPTH−1−P, next state TRIGGERED. If post_count = 0, next state is DONE instead.
  - Otherwise the state remains ARMED; the buffer wraps freely.
- TRIGGERED: every edge writes a sample, increments wr_ptr and decrements post_count. The edge that writes the final post sample moves to DONE.
- DONE: no writes. Memory holds exactly DEPTH samples, oldest at start_addr, trigger at trig_addr. The state holds until arm or reset.
- arm in ARMED, TRIGGERED or DONE restarts the capture exactly as from IDLE. arm has priority over a trigger in the same cycle.
- Reads are allowed in any state. During capture, rd_data returns whatever is currently stored; no ordering guarantee against a same-cycle write to the same address.
- Memory contents are not cleared by reset.
- Configuration inputs are ignored except on the arm cycle.

## Timing
- Reset values: state=IDLE, trig_addr=0, start_addr=0, rd_data=0, rd_valid=0; internal counters are 0.
- arm sampled at edge k → state=ARMED after edge k; the sample at edge k+1 is written at address 0.
- Earliest trigger is at edge k+1+P, the sample written at address P.
- Trigger at edge t → state=TRIGGERED (or DONE if P=DEPTH−1) after edge t.
- DONE is reached after edge t+DEPTH−1−P.
- Read latency is 1 cycle: rd_en at edge r → rd_data and rd_valid=1 after edge r. rd_valid is 0 in the following cycle unless rd_en is held. Back-to-back reads give one word per cycle.
- Reset asserted mid-capture aborts the capture: next state is IDLE, and trig_addr and start_addr return to 0.

## Test plan
- Use DEPTH=16 throughout.
- Reset: outputs at reset values; arm pulse → state=1 next cycle; rd_valid=0 while idle.
- trig_sel=0, mask=0xFFFF, value=0x0005, P=4, probe0 ramps 0,1,2,… from the first ARMED edge → trigger at probe0=5 (address 5), trig_addr=5, start_addr=1, DONE after 11 more edges, addr 1..15 and 0 read back as probe0 values 1..16.
- trig_sel=3, P=0 → trigger on the first sample; trig_addr=0, start_addr=0; DONE 15 edges later; 16 consecutive reads return all samples in order.
- P=15, trigger on probe2 with mask=0x00F0 and value=0x0030; probe2=0x1234 early, 0xAB3F later → no trigger on 0x1234; trigger once 15 samples are held and 0xAB3F appears; DONE on the next cycle.
- Re-arm while TRIGGERED → state=ARMED, wr_ptr restarts at 0, and the previous trigger is discarded.
- Reset asserted during TRIGGERED → state=IDLE next cycle, and no memory writes occur afterwards.

Source files
------------

// File: rtl/ila_if.sv
// ila_if: bundle of probe, trigger-configuration, read-port and status
// signals for the ila core.
//   master : debug host / bench side (drives probes, config, read requests)
//   slave  : ila core side (drives read data and capture status)
// Signals:
//   probe0/1/2   sampled buses, word stored as {probe2, probe1, probe0}
//   arm          single-cycle pulse starting/restarting a capture
//   trig_sel     0/1/2 compare probe0/1/2, 3 = unconditional trigger
//   trig_value   trigger compare value
//   trig_mask    trigger compare mask (1 = bit compared)
//   pre_trigger  samples retained ahead of the trigger sample
//   rd_en        read request
//   rd_addr      read address
//   rd_data      registered read word
//   rd_valid     rd_data strobe
//   state        0=IDLE 1=ARMED 2=TRIGGERED 3=DONE
//   trig_addr    address of the trigger sample
//   start_addr   address of the oldest sample of the window
interface ila_if #(
  parameter int PROBE_WIDTH = 16,
  parameter int DEPTH       = 256,
  parameter int ADDR_W      = $clog2(DEPTH)
);
  logic [PROBE_WIDTH-1:0]   probe0;
  logic [PROBE_WIDTH-1:0]   probe1;
  logic [PROBE_WIDTH-1:0]   probe2;
  logic                     arm;
  logic [1:0]               trig_sel;
  logic [PROBE_WIDTH-1:0]   trig_value;
  logic [PROBE_WIDTH-1:0]   trig_mask;
  logic [ADDR_W-1:0]        pre_trigger;
  logic                     rd_en;
  logic [ADDR_W-1:0]        rd_addr;
  logic [3*PROBE_WIDTH-1:0] rd_data;
  logic                     rd_valid;
  logic [1:0]               state;
  logic [ADDR_W-1:0]        trig_addr;
  logic [ADDR_W-1:0]        start_addr;

  modport master (
    output probe0, probe1, probe2, arm, trig_sel, trig_value, trig_mask,
           pre_trigger, rd_en, rd_addr,
    input  rd_data, rd_valid, state, trig_addr, start_addr
  );

  modport slave (
    input  probe0, probe1, probe2, arm, trig_sel, trig_value, trig_mask,
           pre_trigger, rd_en, rd_addr,
    output rd_data, rd_valid, state, trig_addr, start_addr
  );
endinterface

// File: rtl/ila.sv
// ila: three-probe integrated logic analyzer.
// Samples {probe2, probe1, probe0} every clock while armed into a circular
// memory of DEPTH words, evaluates a masked-compare trigger, and freezes a
// window of pre_trigger samples before and DEPTH-1-pre_trigger samples after
// the trigger sample. A one-cycle-latency read port drains the memory.
// Ports:
//   clk    sole clock, rising edge
//   reset  synchronous, active-high
//   bus    ila_if slave modport (probes, trigger config, read port, status)
module ila #(
  parameter int PROBE_WIDTH = 16,
  parameter int DEPTH       = 256,
  parameter int ADDR_W      = $clog2(DEPTH)
) (
  input  logic   clk,
  input  logic   reset,
  ila_if.slave   bus
);

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    ARMED     = 2'd1,
    TRIGGERED = 2'd2,
    DONE      = 2'd3
  } state_t;

  localparam logic [ADDR_W-1:0] LAST = ADDR_W'(DEPTH - 1);
  localparam logic [ADDR_W-1:0] ONE  = ADDR_W'(1);

  state_t state_q, state_d;

  logic [ADDR_W-1:0]      wr_ptr;
  logic [ADDR_W-1:0]      pre_count;
  logic [ADDR_W-1:0]      post_count;
  logic [ADDR_W-1:0]      p_reg;
  logic [1:0]             sel_reg;
  logic [PROBE_WIDTH-1:0] value_reg;
  logic [PROBE_WIDTH-1:0] mask_reg;
  logic [ADDR_W-1:0]      trig_addr_q;
  logic [ADDR_W-1:0]      start_addr_q;

  logic [PROBE_WIDTH-1:0] sel_probe;
  logic                   match;
  logic                   pre_full;
  logic                   do_write;
  logic                   do_trigger;

  logic [3*PROBE_WIDTH-1:0] mem [DEPTH];
  logic [3*PROBE_WIDTH-1:0] rd_data_q;
  logic                     rd_valid_q;

  // Trigger compare against the configuration latched on the arm cycle.
  always_comb begin
    sel_probe = bus.probe0;
    case (sel_reg)
      2'd1:    sel_probe = bus.probe1;
      2'd2:    sel_probe = bus.probe2;
      default: sel_probe = bus.probe0;
    endcase
  end

  assign match    = (sel_reg == 2'd3) ||
                    ((sel_probe & mask_reg) == (value_reg & mask_reg));
  assign pre_full = (pre_count == p_reg);

  // Next state and per-edge strobes. arm wins over everything, including a
  // same-cycle trigger, and suppresses the write on its own edge.
  always_comb begin
    state_d    = state_q;
    do_write   = 1'b0;
    do_trigger = 1'b0;
    if (bus.arm) begin
      state_d = ARMED;
    end else begin
      case (state_q)
        ARMED: begin
          do_write = 1'b1;
          if (pre_full && match) begin
            do_trigger = 1'b1;
            state_d    = (p_reg == LAST) ? DONE : TRIGGERED;
          end
        end
        TRIGGERED: begin
          do_write = 1'b1;
          // TRIGGERED is only entered with post_count >= 1.
          if (post_count == ONE) state_d = DONE;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr       <= '0;
      pre_count    <= '0;
      post_count   <= '0;
      p_reg        <= '0;
      sel_reg      <= '0;
      value_reg    <= '0;
      mask_reg     <= '0;
      trig_addr_q  <= '0;
      start_addr_q <= '0;
    end else if (bus.arm) begin
      wr_ptr       <= '0;
      pre_count    <= '0;
      post_count   <= '0;
      p_reg        <= bus.pre_trigger;
      sel_reg      <= bus.trig_sel;
      value_reg    <= bus.trig_value;
      mask_reg     <= bus.trig_mask;
      trig_addr_q  <= '0;
      start_addr_q <= '0;
    end else if (do_write) begin
      wr_ptr <= wr_ptr + ONE;
      if (state_q == ARMED && !pre_full) pre_count <= pre_count + ONE;
      if (do_trigger) begin
        trig_addr_q  <= wr_ptr;
        start_addr_q <= wr_ptr - p_reg;
        post_count   <= LAST - p_reg;
      end else if (state_q == TRIGGERED) begin
        post_count <= post_count - ONE;
      end
    end
  end

  // Sample memory: not reset, written only while capturing.
  always_ff @(posedge clk) begin
    if (do_write && !reset)
      mem[wr_ptr] <= {bus.probe2, bus.probe1, bus.probe0};
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rd_data_q  <= '0;
      rd_valid_q <= 1'b0;
    end else begin
      rd_valid_q <= bus.rd_en;
      if (bus.rd_en) rd_data_q <= mem[bus.rd_addr];
    end
  end

  assign bus.state      = state_q;
  assign bus.trig_addr  = trig_addr_q;
  assign bus.start_addr = start_addr_q;
  assign bus.rd_data    = rd_data_q;
  assign bus.rd_valid   = rd_valid_q;

endmodule

// File: tb/tb_ila.sv
// tb_ila: self-checking bench for ila with DEPTH=16. Inputs are driven on
// the falling edge, outputs checked on the falling edge. Read expectations
// come from a bench-side sample memory and are queued when a read is issued.
module tb_ila;

  localparam int PW    = 16;
  localparam int DEPTH = 16;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  ila_if #(.PROBE_WIDTH(PW), .DEPTH(DEPTH)) bus ();

  ila #(.PROBE_WIDTH(PW), .DEPTH(DEPTH)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int checks = 0;
  int fails  = 0;

  logic [3*PW-1:0] exp_q [$];
  logic [3*PW-1:0] model_mem [DEPTH];
  int              wp;
  bit              writing;

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic do_arm(input logic [1:0] sel, input logic [PW-1:0] val,
                        input logic [PW-1:0] mask, input logic [3:0] p);
    bus.arm         = 1'b1;
    bus.trig_sel    = sel;
    bus.trig_value  = val;
    bus.trig_mask   = mask;
    bus.pre_trigger = p;
    bus.probe0      = 16'hDEAD;
    tick();
    bus.arm         = 1'b0;
    // Config must be ignored outside the arm cycle.
    bus.trig_sel    = 2'($urandom);
    bus.trig_value  = 16'($urandom);
    bus.trig_mask   = 16'($urandom);
    bus.pre_trigger = 4'($urandom);
    wp      = 0;
    writing = 1'b1;
  endtask

  task automatic sample(input logic [PW-1:0] p0, input logic [PW-1:0] p1,
                        input logic [PW-1:0] p2);
    bus.probe0 = p0;
    bus.probe1 = p1;
    bus.probe2 = p2;
    if (writing) begin
      model_mem[wp] = {p2, p1, p0};
      wp = (wp + 1) % DEPTH;
    end
    tick();
  endtask

  task automatic issue_reads(input int start, input int n);
    for (int j = 0; j < n; j++) begin
      bus.rd_en   = 1'b1;
      bus.rd_addr = 4'(start + j);
      exp_q.push_back(model_mem[4'(start + j)]);
      tick();
    end
    bus.rd_en = 1'b0;
    tick();
  endtask

  // Scoreboard: each valid read word is compared with the oldest expectation.
  always @(negedge clk) begin
    if (bus.rd_valid === 1'b1) begin
      logic [3*PW-1:0] e;
      checks++;
      if (exp_q.size() == 0) begin
        fails++;
        $display("FAIL rd_unexpected: rd_valid=1 with no read outstanding, data=%h", bus.rd_data);
      end else begin
        e = exp_q.pop_front();
        if (bus.rd_data !== e) begin
          fails++;
          $display("FAIL rd_data: got %h expected %h", bus.rd_data, e);
        end
      end
    end
  end

  task automatic test_reset();
    reset = 1'b1;
    tick(); tick();
    reset = 1'b0;
    checks++; if (bus.state !== 2'd0) begin fails++; $display("FAIL reset_state: got %0d expected 0", bus.state); end
    checks++; if (bus.trig_addr !== 4'd0) begin fails++; $display("FAIL reset_trig_addr: got %0d expected 0", bus.trig_addr); end
    checks++; if (bus.start_addr !== 4'd0) begin fails++; $display("FAIL reset_start_addr: got %0d expected 0", bus.start_addr); end
    checks++; if (bus.rd_data !== 48'd0) begin fails++; $display("FAIL reset_rd_data: got %h expected 0", bus.rd_data); end
    checks++; if (bus.rd_valid !== 1'b0) begin fails++; $display("FAIL reset_rd_valid: got %b expected 0", bus.rd_valid); end
    tick();
    checks++; if (bus.state !== 2'd0) begin fails++; $display("FAIL idle_hold: got %0d expected 0", bus.state); end
    checks++; if (bus.rd_valid !== 1'b0) begin fails++; $display("FAIL idle_rd_valid: got %b expected 0", bus.rd_valid); end
  endtask

  task automatic test_ramp_trigger();
    do_arm(2'd0, 16'h0005, 16'hFFFF, 4'd4);
    checks++; if (bus.state !== 2'd1) begin fails++; $display("FAIL ramp_arm: state %0d expected 1", bus.state); end
    for (int i = 0; i <= 16; i++) begin
      if (i == 16) writing = 1'b1;
      sample(16'(i), 16'(i * 3 + 7), 16'hF000 | 16'(i));
      if (i < 5) begin
        checks++; if (bus.state !== 2'd1) begin fails++; $display("FAIL ramp_armed i=%0d: state %0d expected 1", i, bus.state); end
      end else if (i < 16) begin
        checks++; if (bus.state !== 2'd2) begin fails++; $display("FAIL ramp_trig i=%0d: state %0d expected 2", i, bus.state); end
      end else begin
        checks++; if (bus.state !== 2'd3) begin fails++; $display("FAIL ramp_done: state %0d expected 3", bus.state); end
      end
      if (i == 5) begin
        checks++; if (bus.trig_addr !== 4'd5) begin fails++; $display("FAIL ramp_trig_addr: got %0d expected 5", bus.trig_addr); end
        checks++; if (bus.start_addr !== 4'd1) begin fails++; $display("FAIL ramp_start_addr: got %0d expected 1", bus.start_addr); end
      end
    end
    writing = 1'b0;
    sample(16'd99, 16'd99, 16'd99);
    checks++; if (bus.state !== 2'd3) begin fails++; $display("FAIL ramp_done_hold: state %0d expected 3", bus.state); end
    // Oldest sample (probe0=1) at address 1, newest (probe0=16) at 0.
    checks++; if (model_mem[0][15:0] !== 16'd16) begin fails++; $display("FAIL ramp_model_wrap: got %0d expected 16", model_mem[0][15:0]); end
    issue_reads(1, 16);
    checks++; if (bus.rd_valid !== 1'b0) begin fails++; $display("FAIL ramp_rd_valid_drop: got %b expected 0", bus.rd_valid); end
  endtask

  task automatic test_unconditional();
    do_arm(2'd3, 16'h1234, 16'hFFFF, 4'd0);
    for (int i = 0; i < 16; i++) begin
      sample(16'($urandom), 16'($urandom), 16'($urandom));
      if (i == 0) begin
        checks++; if (bus.trig_addr !== 4'd0) begin fails++; $display("FAIL uncond_trig_addr: got %0d expected 0", bus.trig_addr); end
        checks++; if (bus.start_addr !== 4'd0) begin fails++; $display("FAIL uncond_start_addr: got %0d expected 0", bus.start_addr); end
      end
      if (i < 15) begin
        checks++; if (bus.state !== 2'd2) begin fails++; $display("FAIL uncond_trig i=%0d: state %0d expected 2", i, bus.state); end
      end else begin
        checks++; if (bus.state !== 2'd3) begin fails++; $display("FAIL uncond_done: state %0d expected 3", bus.state); end
      end
    end
    writing = 1'b0;
    issue_reads(0, 16);
  endtask

  task automatic test_full_pretrigger();
    do_arm(2'd2, 16'h0030, 16'h00F0, 4'd15);
    for (int i = 0; i < 18; i++) begin
      sample(16'h0030, 16'h0030, (i < 15) ? 16'h1234 : 16'h12C4);
      checks++; if (bus.state !== 2'd1) begin fails++; $display("FAIL pre_armed i=%0d: state %0d expected 1", i, bus.state); end
    end
    sample(16'h0030, 16'h0030, 16'hAB3F);
    writing = 1'b0;
    checks++; if (bus.state !== 2'd3) begin fails++; $display("FAIL pre_done: state %0d expected 3", bus.state); end
    checks++; if (bus.trig_addr !== 4'd2) begin fails++; $display("FAIL pre_trig_addr: got %0d expected 2", bus.trig_addr); end
    checks++; if (bus.start_addr !== 4'd3) begin fails++; $display("FAIL pre_start_addr: got %0d expected 3", bus.start_addr); end
    issue_reads(3, 16);
  endtask

  task automatic test_rearm();
    do_arm(2'd3, 16'h0000, 16'h0000, 4'd2);
    for (int i = 0; i < 5; i++) sample(16'h0500 | 16'(i), 16'h0, 16'h0);
    checks++; if (bus.state !== 2'd2) begin fails++; $display("FAIL rearm_pre: state %0d expected 2", bus.state); end
    checks++; if (bus.trig_addr !== 4'd2) begin fails++; $display("FAIL rearm_first_trig: got %0d expected 2", bus.trig_addr); end
    do_arm(2'd0, 16'h00AA, 16'hFFFF, 4'd1);
    checks++; if (bus.state !== 2'd1) begin fails++; $display("FAIL rearm_state: state %0d expected 1", bus.state); end
    sample(16'h0011, 16'h2222, 16'h3333);
    checks++; if (bus.state !== 2'd1) begin fails++; $display("FAIL rearm_armed: state %0d expected 1", bus.state); end
    sample(16'h00AA, 16'h2223, 16'h3334);
    checks++; if (bus.state !== 2'd2) begin fails++; $display("FAIL rearm_trig: state %0d expected 2", bus.state); end
    checks++; if (bus.trig_addr !== 4'd1) begin fails++; $display("FAIL rearm_trig_addr: got %0d expected 1", bus.trig_addr); end
    checks++; if (bus.start_addr !== 4'd0) begin fails++; $display("FAIL rearm_start_addr: got %0d expected 0", bus.start_addr); end
    for (int i = 0; i < 14; i++) sample(16'h0700 | 16'(i), 16'(i), 16'(~i));
    writing = 1'b0;
    checks++; if (bus.state !== 2'd3) begin fails++; $display("FAIL rearm_done: state %0d expected 3", bus.state); end
    issue_reads(0, 16);
  endtask

  task automatic test_reset_abort();
    do_arm(2'd3, 16'h0, 16'h0, 4'd0);
    for (int i = 0; i < 4; i++) sample(16'h0900 | 16'(i), 16'h0901, 16'h0902);
    checks++; if (bus.state !== 2'd2) begin fails++; $display("FAIL abort_pre: state %0d expected 2", bus.state); end
    writing = 1'b0;
    reset = 1'b1;
    sample(16'hBAD0, 16'hBAD1, 16'hBAD2);
    reset = 1'b0;
    checks++; if (bus.state !== 2'd0) begin fails++; $display("FAIL abort_state: state %0d expected 0", bus.state); end
    checks++; if (bus.trig_addr !== 4'd0) begin fails++; $display("FAIL abort_trig_addr: got %0d expected 0", bus.trig_addr); end
    checks++; if (bus.start_addr !== 4'd0) begin fails++; $display("FAIL abort_start_addr: got %0d expected 0", bus.start_addr); end
    for (int i = 0; i < 5; i++) sample(16'hCC00 | 16'(i), 16'hCCCC, 16'hCCCD);
    checks++; if (bus.state !== 2'd0) begin fails++; $display("FAIL abort_idle: state %0d expected 0", bus.state); end
    issue_reads(0, 16);
  endtask

  initial begin
    reset           = 1'b1;
    bus.probe0      = '0;
    bus.probe1      = '0;
    bus.probe2      = '0;
    bus.arm         = 1'b0;
    bus.trig_sel    = '0;
    bus.trig_value  = '0;
    bus.trig_mask   = '0;
    bus.pre_trigger = '0;
    bus.rd_en       = 1'b0;
    bus.rd_addr     = '0;
    wp              = 0;
    writing         = 1'b0;
    tick();
    test_reset();
    test_ramp_trigger();
    test_unconditional();
    test_full_pretrigger();
    test_rearm();
    test_reset_abort();
    tick();
    checks++;
    if (exp_q.size() != 0) begin
      fails++;
      $display("FAIL rd_outstanding: %0d reads never returned, expected 0", exp_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
